// File: rtl/uart_tx_core_if.sv
// Parallel-side and line-side signals of the UART transmitter.
// The master modport belongs to whoever feeds bytes in; the slave modport
// is the transmitter itself.
interface uart_tx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic [5:0]            prescale;
  logic                  parity_enable;
  logic                  parity_type;
  logic                  TX_OUT;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output P_DATA, data_valid, prescale, parity_enable, parity_type,
    input  TX_OUT, busy, tx_done
  );

  modport slave (
    input  P_DATA, data_valid, prescale, parity_enable, parity_type,
    output TX_OUT, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts `prescale` clocks (0 acts as 1).
// The byte and the line configuration are latched when the frame is
// accepted, so input changes mid-frame only affect the next frame.
// All outputs come straight from flops.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_core_if.slave  bus
);

  localparam int IDX_W = ($clog2(DATA_WIDTH) < 4) ? 4 : $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [5:0]            cnt, cnt_nxt;
  logic [5:0]            last_cnt, last_cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [DATA_WIDTH-1:0] data_shift;
  logic                  par_en_q, par_en_nxt;
  logic                  par_type_q, par_type_nxt;
  logic                  tx_out_nxt, busy_nxt, tx_done_nxt;
  logic                  bit_end;
  logic                  par_bit;

  assign bit_end = (cnt == last_cnt);
  // Odd parity is the complement of even parity over the latched byte.
  assign par_bit = (^data_q) ^ par_type_q;

  // Next-state, counter, shadow-capture and registered-output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_cnt_nxt = last_cnt;
    idx_nxt      = idx;
    data_nxt     = data_q;
    par_en_nxt   = par_en_q;
    par_type_nxt = par_type_q;
    tx_done_nxt  = 1'b0;

    if (state != IDLE) begin
      cnt_nxt = bit_end ? 6'd0 : cnt + 6'd1;
    end

    case (state)
      IDLE: begin
        cnt_nxt = 6'd0;
        idx_nxt = '0;
        if (bus.data_valid) begin
          state_nxt    = START;
          data_nxt     = bus.P_DATA;
          last_cnt_nxt = (bus.prescale == 6'd0) ? 6'd0 : bus.prescale - 6'd1;
          par_en_nxt   = bus.parity_enable;
          par_type_nxt = bus.parity_type;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == LAST_IDX) begin
            state_nxt = par_en_q ? PARITY : STOP;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_nxt   = IDLE;
          tx_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decoded from the state being entered so TX_OUT can be
    // registered without a cycle of lag.
    data_shift = data_nxt >> idx_nxt;
    case (state_nxt)
      START:   tx_out_nxt = 1'b0;
      DATA:    tx_out_nxt = data_shift[0];
      PARITY:  tx_out_nxt = par_bit;
      default: tx_out_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // FSM, bit timing and shadow configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      last_cnt   <= 6'd0;
      idx        <= '0;
      // NOTE: the shadow registers are reset too; they are few flops and this
      // keeps X out of the parity path after power-up.
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_cnt   <= last_cnt_nxt;
      idx        <= idx_nxt;
      data_q     <= data_nxt;
      par_en_q   <= par_en_nxt;
      par_type_q <= par_type_nxt;
    end
  end

  // Registered line and status outputs; reset forces the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.TX_OUT  <= 1'b1;
      bus.busy    <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.TX_OUT  <= tx_out_nxt;
      bus.busy    <= busy_nxt;
      bus.tx_done <= tx_done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus pushes the expected frame
// when a byte is strobed in; a monitor pops it when busy rises and walks
// the serial line cycle by cycle, then checks the tx_done pulse.
module tb_uart_tx_core;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  uart_tx_core_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         pe;
    bit         par;
  } frame_t;

  frame_t exp_q[$];
  int     checks      = 0;
  int     failures    = 0;
  int     frames_seen = 0;
  bit     mon_en      = 1'b0;

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Walk one frame; entered on the first busy cycle, returns one cycle
  // after the tx_done cycle.
  task automatic run_frame(frame_t f, int n);
    int   nbits;
    int   good;
    logic exp_bit;
    nbits = f.pe ? DW + 3 : DW + 2;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                       exp_bit = 1'b0;
      else if (b <= DW)                 exp_bit = f.data[b-1];
      else if (f.pe && (b == DW + 1))   exp_bit = f.par;
      else                              exp_bit = 1'b1;
      good = 0;
      for (int c = 0; c < f.p; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (bus.TX_OUT === exp_bit && bus.busy === 1'b1 && bus.tx_done === 1'b0)
          good++;
      end
      check($sformatf("frame%0d_bit%0d_good_cycles", n, b), good, f.p);
    end
    @(negedge clk);
    check($sformatf("frame%0d_end_busy_done", n), {bus.busy, bus.tx_done}, 2'b01);
    @(negedge clk);
    check($sformatf("frame%0d_done_one_cycle", n), bus.tx_done, 1'b0);
  endtask

  // Monitor: pop the expected frame whenever a frame starts on the line.
  initial begin
    @(negedge clk);
    forever begin
      if (mon_en && bus.busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          @(negedge clk);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          run_frame(f, frames_seen);
          frames_seen++;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic push(logic [7:0] d, logic [5:0] p, bit pe, bit par);
    frame_t f;
    f.data = d;
    f.p    = (p == 6'd0) ? 1 : int'(p);
    f.pe   = pe;
    f.par  = par;
    exp_q.push_back(f);
  endtask

  task automatic drive(logic [7:0] d, logic [5:0] p, bit pe, bit pt);
    bus.P_DATA        = d;
    bus.prescale      = p;
    bus.parity_enable = pe;
    bus.parity_type   = pt;
    bus.data_valid    = 1'b1;
  endtask

  // One-cycle strobe starting just after a rising edge.
  task automatic send(logic [7:0] d, logic [5:0] p, bit pe, bit pt, bit par, bit expect_it);
    @(posedge clk);
    #1;
    drive(d, p, pe, pt);
    if (expect_it) push(d, p, pe, par);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && bus.busy === 1'b0 && bus.tx_done === 1'b0) && n < budget);
    if (n >= budget) check("wait_idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_done !== 1'b1 && n < budget);
    if (n >= budget) check("wait_done_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    int busy_seen;
    bus.P_DATA        = '0;
    bus.data_valid    = 1'b0;
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_out", bus.TX_OUT, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_tx_done", bus.tx_done, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Even parity, 0xA5: parity bit 0, 88 busy cycles.
    send(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(300);

    // Odd parity: 0x01 -> 0, 0x00 -> 1.
    send(8'h01, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle(300);
    send(8'h00, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle(300);

    // Parity disabled, 16-cycle bits, 160 busy cycles.
    send(8'hFF, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(400);

    // Strobe mid-frame is ignored; strobe in the tx_done cycle is accepted.
    send(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (30) @(posedge clk);
    send(8'h3C, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(200);
    push(8'h3C, 6'd8, 1'b0, 1'b0);
    drive(8'h3C, 6'd8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    wait_idle(300);

    // Reset during data bit 3 of 0x42 (bit 3 is 0) aborts the frame.
    mon_en = 1'b0;
    send(8'h42, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (35) @(posedge clk);
    #3;
    check("abort_pre_tx_out", bus.TX_OUT, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_tx_out", bus.TX_OUT, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) done_seen++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("abort_no_tx_done", done_seen, 0);
    check("abort_stays_idle", busy_seen, 0);
    mon_en = 1'b1;
    send(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(300);

    // Mid-frame config changes do not affect the frame in flight.
    send(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    bus.prescale    = 6'd32;
    bus.parity_type = 1'b1;
    wait_idle(300);
    send(8'h0F, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle(800);

    // prescale 0 behaves as 1-cycle bits; 0x96 has even parity bit 0.
    send(8'h96, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(100);

    check("frames_monitored", frames_seen, 10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial UART transmitter paired with the existing oversampled receiver. It accepts one parallel byte with a single-cycle valid strobe and shifts out a frame on TX_OUT: start bit, 8 data bits LSB-first, optional parity bit, and one stop bit. Each bit lasts `prescale` clk cycles, so the TX baud matches the RX setup on the same clock. It sits between the system register/FIFO side and the pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst  input  1  asynchronous active-high reset.
P_DATA  input  DATA_WIDTH  byte to transmit.
data_valid  input  1  single-cycle strobe; P_DATA is valid this cycle.
prescale  input  6  clk cycles per bit; 0 is treated as 1.
parity_enable  input  1  1 inserts a parity bit after the data bits.
parity_type  input  1  0 = even, 1 = odd.
TX_OUT  output  1  serial line, idle high, registered.
busy  output  1  high while a frame is in flight, registered.
tx_done  output  1  one-cycle pulse after the stop bit completes, registered.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: TX_OUT=1, busy=0, tx_done=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately: TX_OUT=1, busy=0, and no tx_done pulse.
- FSM states: IDLE -> START -> DATA -> (PARITY if enabled) -> STOP -> IDLE.
- IDLE:
  - TX_OUT=1, busy=0.
  - When data_valid=1 in cycle N, capture P_DATA, prescale, parity_enable and parity_type into shadow registers.
  - Go to START. TX_OUT=0 and busy=1 from cycle N+1.
- Bit timing:
  - An edge counter counts 0..P-1, where P is the captured prescale (0 maps to 1).
  - The bit ends when the count reaches P-1; the counter then wraps to 0 and the FSM or bit index advances.
- DATA: bit index 0..DATA_WIDTH-1, LSB first. TX_OUT = data[index].
- PARITY: TX_OUT = ^data when type is even, ~^data when type is odd. The value is computed from the captured byte.
- STOP: TX_OUT=1 for P cycles.
- End of frame:
  - On the last STOP cycle the FSM returns to IDLE.
  - Next cycle: busy=0 and tx_done=1 for exactly one cycle.
- Frame length: busy is high for exactly (DATA_WIDTH+2+parity_enable)*P cycles.
- data_valid while busy=1 is ignored. No queuing, no effect on the current frame.
- A new data_valid in the same cycle as the tx_done pulse is accepted. Back-to-back frames are therefore separated by zero idle bit-times.
- Changes to prescale, parity_enable or parity_type mid-frame have no effect until the next accepted frame.
- TX_OUT is glitch-free: it is driven directly from a flop.
- Edge counter is 6 bits; bit counter is at least 4 bits. No overflow is possible for P ≤ 63.

Test Plan:
- Even parity frame: rst pulse, prescale=8, parity_enable=1, parity_type=0, P_DATA=0xA5 strobed at cycle 0 -> TX_OUT from cycle 1:
  - 0 for 8 cycles;
  - bits 1,0,1,0,0,1,0,1, each for 8 cycles;
  - parity 0 for 8 cycles;
  - stop 1 for 8 cycles;
  - busy high for 88 cycles; tx_done pulses at cycle 89.
- Odd parity: same as above with parity_type=1 and P_DATA=0x01 -> parity bit = 0. With P_DATA=0x00 -> parity bit = 1.
- Parity disabled: parity_enable=0, prescale=16, P_DATA=0xFF -> frame of 10 bits × 16 = 160 busy cycles, stop immediately after the 8th data bit, no parity bit.
- Ignore and back-to-back:
  - Strobe P_DATA=0x3C mid-frame of a 0x55 transmission -> no change to the serial stream.
  - Strobe 0x3C in the tx_done cycle -> the next start bit begins the following cycle.
- Reset mid-frame: assert rst during data bit 3 -> TX_OUT=1 and busy=0 asynchronously, no tx_done. After release, a new 0x81 frame transmits correctly.
- Config shadowing and prescale=0:
  - Change prescale 8->32 and parity_type mid-frame -> the current frame is unaffected; the next frame uses 32-cycle bits.
  - prescale=0 -> every bit lasts 1 cycle.
